// File: rtl/fsm_stim_pkg.sv
// Shared types and constants for the FSM stimulus sequencer / response checker.
// Holds the controller state encoding, the bit layout of one table entry and
// the width of the step index.
package fsm_stim_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  localparam int STEP_IDX_W = 4;

  // Entry layout: {a, b, exp_y0, exp_y1, chk}
  localparam int ENTRY_W    = 5;
  localparam int POS_A      = 4;
  localparam int POS_B      = 3;
  localparam int POS_EXP_Y0 = 2;
  localparam int POS_EXP_Y1 = 1;
  localparam int POS_CHK    = 0;

  typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/fsm_stim_rom.sv
// Stimulus/expectation table for the checker. Replace this file per DUT.
// Ports:
//   idx   in  STEP_IDX_W  step index
//   entry out ENTRY_W     {a, b, exp_y0, exp_y1, chk} for that step
module fsm_stim_rom
  import fsm_stim_pkg::*;
(
  input  logic [STEP_IDX_W-1:0] idx,
  output entry_t                entry
);

  always_comb begin
    entry = '0;
    case (idx)
      4'd0:    entry = 5'b00_00_1;
      4'd1:    entry = 5'b00_00_1;
      4'd2:    entry = 5'b11_11_1;
      4'd3:    entry = 5'b11_11_1;
      4'd4:    entry = 5'b10_10_1;
      4'd5:    entry = 5'b10_10_1;
      4'd6:    entry = 5'b00_00_1;
      4'd7:    entry = 5'b01_01_0;
      default: entry = '0;
    endcase
  end

endmodule

// File: rtl/fsm_stim_checker.sv
// Synthesizable stimulus sequencer and response checker for two-input /
// two-output FSMs. Plays the table from fsm_stim_rom into a/b, waits SETTLE
// cycles, samples y0/y1 and compares against the table expectation.
// Optional build macro: FSM_STIM_LOOP_EN -- restart automatically one cycle
// after DONE, accumulating err_cnt/fail_* across loops.
// Ports:
//   clk, reset        clock (rising edge), async active-high reset
//   start             one-cycle pulse, begins a run when not busy
//   y0, y1            DUT outputs
//   a, b              registered DUT stimulus
//   busy, done, pass  run status (pass = done && err_cnt==0)
//   err_cnt           saturating mismatch count
//   fail_step         first mismatching step, valid when fail_valid
//
// state  | meaning
// IDLE   | waiting for start
// DRIVE  | a/b held, settle timer running
// SAMPLE | compare y0/y1, advance to next step or finish
// DONE   | run complete, done held until next start
module fsm_stim_checker
  import fsm_stim_pkg::*;
#(
  parameter int NUM_STEPS = 8,
  parameter int SETTLE    = 1,
  parameter int ERR_W     = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  y0,
  input  logic                  y1,
  output logic                  a,
  output logic                  b,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ERR_W-1:0]      err_cnt,
  output logic [STEP_IDX_W-1:0] fail_step,
  output logic                  fail_valid
);

  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0]      CNT_INIT  = CNT_W'(SETTLE - 1);
  localparam logic [STEP_IDX_W-1:0] LAST_STEP = STEP_IDX_W'(NUM_STEPS - 1);

  state_t                  state, state_nxt;
  logic [STEP_IDX_W-1:0]   step, step_nxt;
  logic [CNT_W-1:0]        cnt, cnt_nxt;
  logic                    a_nxt, b_nxt, busy_nxt, done_nxt, pass_nxt, fv_nxt;
  logic [ERR_W-1:0]        err_nxt;
  logic [STEP_IDX_W-1:0]   fs_nxt;
  // Expectation of the entry currently on a/b, latched with it so the ROM only
  // needs one read port (the entry to load next).
  logic [1:0]              exp_q, exp_nxt;
  logic                    chk_q, chk_nxt;
  logic [STEP_IDX_W-1:0]   rom_idx;
  entry_t                  rom_entry;
  logic                    load_first, load_next, clr_stats, mismatch;

  fsm_stim_rom u_rom (
    .idx   (rom_idx),
    .entry (rom_entry)
  );

  // Index past the last step is never presented to the table.
  assign rom_idx  = (state == SAMPLE && step != LAST_STEP) ? step + 1'b1 : '0;
  assign mismatch = chk_q && ({y0, y1} != exp_q);

  always_comb begin
    state_nxt  = state;
    step_nxt   = step;
    cnt_nxt    = cnt;
    a_nxt      = a;
    b_nxt      = b;
    exp_nxt    = exp_q;
    chk_nxt    = chk_q;
    busy_nxt   = busy;
    done_nxt   = done;
    err_nxt    = err_cnt;
    fs_nxt     = fail_step;
    fv_nxt     = fail_valid;
    load_first = 1'b0;
    load_next  = 1'b0;
    clr_stats  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          load_first = 1'b1;
          clr_stats  = 1'b1;
        end
      end
      DRIVE: begin
        if (cnt == '0) state_nxt = SAMPLE;
        else           cnt_nxt   = cnt - 1'b1;
      end
      SAMPLE: begin
        if (mismatch) begin
          if (err_cnt != {ERR_W{1'b1}}) err_nxt = err_cnt + 1'b1;
          if (!fail_valid) begin
            fs_nxt = step;
            fv_nxt = 1'b1;
          end
        end
        if (step == LAST_STEP) begin
          state_nxt = DONE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
        end else begin
          load_next = 1'b1;
        end
      end
      DONE: begin
        if (start) begin
          load_first = 1'b1;
          clr_stats  = 1'b1;
        end
`ifdef FSM_STIM_LOOP_EN
        else begin
          load_first = 1'b1;
        end
`endif
      end
      default: state_nxt = IDLE;
    endcase

    if (load_first || load_next) begin
      state_nxt = DRIVE;
      step_nxt  = load_first ? '0 : step + 1'b1;
      cnt_nxt   = CNT_INIT;
      a_nxt     = rom_entry[POS_A];
      b_nxt     = rom_entry[POS_B];
      exp_nxt   = {rom_entry[POS_EXP_Y0], rom_entry[POS_EXP_Y1]};
      chk_nxt   = rom_entry[POS_CHK];
      busy_nxt  = 1'b1;
      done_nxt  = 1'b0;
    end

    if (clr_stats) begin
      err_nxt = '0;
      fs_nxt  = '0;
      fv_nxt  = 1'b0;
    end

    pass_nxt = done_nxt && (err_nxt == '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      step       <= '0;
      cnt        <= '0;
      a          <= 1'b0;
      b          <= 1'b0;
      exp_q      <= '0;
      chk_q      <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      pass       <= 1'b0;
      err_cnt    <= '0;
      fail_step  <= '0;
      fail_valid <= 1'b0;
    end else begin
      state      <= state_nxt;
      step       <= step_nxt;
      cnt        <= cnt_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      exp_q      <= exp_nxt;
      chk_q      <= chk_nxt;
      busy       <= busy_nxt;
      done       <= done_nxt;
      pass       <= pass_nxt;
      err_cnt    <= err_nxt;
      fail_step  <= fs_nxt;
      fail_valid <= fv_nxt;
    end
  end

endmodule

// File: tb/tb_fsm_stim_checker.sv
// Bench for fsm_stim_checker. Three instances: default parameters with a
// configurable DUT model (loopback / inverted / delayed), SETTLE=3 with a
// one-cycle delayed loopback, and ERR_W=2 with an inverted DUT.
module tb_fsm_stim_checker;

  typedef struct {
    int err;
    int fv;
    int fs;
    int pass;
    int cyc;
  } res_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [2:0] start = '0;
  int n_chk = 0;
  int n_fail = 0;
  int sel = 0;

  logic [1:0] tab_ab  [8] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
  logic [1:0] tab_exp [8] = '{2'b00, 2'b00, 2'b11, 2'b11, 2'b10, 2'b10, 2'b00, 2'b01};
  bit         tab_chk [8] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
  logic [1:0] last_ab [3] = '{2'b00, 2'b00, 2'b00};

  res_t       res_q[$];
  logic [1:0] ab_q[$];

  always #5 clk = ~clk;

  // instance 0: selectable DUT model
  logic a0, b0, busy0, done0, pass0, fv0, y0_0, y1_0;
  logic [3:0] err0, fs0;
  logic [1:0] d1_0 = '0, d2_0 = '0, src0;
  int   dly0 = 0;
  bit   inv0 = 1'b0;
  always @(posedge clk) begin
    d1_0 <= {a0, b0};
    d2_0 <= d1_0;
  end
  always_comb begin
    src0 = (dly0 == 0) ? {a0, b0} : (dly0 == 1) ? d1_0 : d2_0;
    y0_0 = src0[1] ^ inv0;
    y1_0 = src0[0];
  end

  fsm_stim_checker u_dut0 (
    .clk(clk), .reset(reset), .start(start[0]), .y0(y0_0), .y1(y1_0),
    .a(a0), .b(b0), .busy(busy0), .done(done0), .pass(pass0),
    .err_cnt(err0), .fail_step(fs0), .fail_valid(fv0));

  // instance 1: SETTLE=3, one-cycle registered loopback
  logic a1, b1, busy1, done1, pass1, fv1;
  logic [3:0] err1, fs1;
  logic [1:0] d1_1 = '0;
  always @(posedge clk) d1_1 <= {a1, b1};

  fsm_stim_checker #(.SETTLE(3)) u_dut1 (
    .clk(clk), .reset(reset), .start(start[1]), .y0(d1_1[1]), .y1(d1_1[0]),
    .a(a1), .b(b1), .busy(busy1), .done(done1), .pass(pass1),
    .err_cnt(err1), .fail_step(fs1), .fail_valid(fv1));

  // instance 2: ERR_W=2, inverted DUT
  logic a2, b2, busy2, done2, pass2, fv2, y0_2, y1_2;
  logic [1:0] err2;
  logic [3:0] fs2;
  assign y0_2 = ~a2;
  assign y1_2 = b2;

  fsm_stim_checker #(.ERR_W(2)) u_dut2 (
    .clk(clk), .reset(reset), .start(start[2]), .y0(y0_2), .y1(y1_2),
    .a(a2), .b(b2), .busy(busy2), .done(done2), .pass(pass2),
    .err_cnt(err2), .fail_step(fs2), .fail_valid(fv2));

  logic [1:0] obs_ab;
  logic       obs_busy, obs_done, obs_pass, obs_fv;
  logic [3:0] obs_err, obs_fs;
  always_comb begin
    case (sel)
      1: begin
        obs_ab = {a1, b1}; obs_busy = busy1; obs_done = done1; obs_pass = pass1;
        obs_fv = fv1; obs_err = err1; obs_fs = fs1;
      end
      2: begin
        obs_ab = {a2, b2}; obs_busy = busy2; obs_done = done2; obs_pass = pass2;
        obs_fv = fv2; obs_err = {2'b00, err2}; obs_fs = fs2;
      end
      default: begin
        obs_ab = {a0, b0}; obs_busy = busy0; obs_done = done0; obs_pass = pass0;
        obs_fv = fv0; obs_err = err0; obs_fs = fs0;
      end
    endcase
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: at step k the DUT output seen at the sample cycle reflects the
  // a/b that were applied dly cycles earlier.
  function automatic res_t model(input int settle, input int dly, input bit inv,
                                 input logic [1:0] prev, input int errmax);
    res_t r;
    int idx;
    logic [1:0] src, y;
    r.err = 0; r.fv = 0; r.fs = 0;
    for (int k = 0; k < 8; k++) begin
      idx = k * (settle + 1) + settle - dly;
      src = (idx < 0) ? prev : tab_ab[idx / (settle + 1)];
      y   = {src[1] ^ inv, src[0]};
      if (tab_chk[k] && y != tab_exp[k]) begin
        if (r.err < errmax) r.err++;
        if (r.fv == 0) begin
          r.fv = 1;
          r.fs = k;
        end
      end
    end
    r.pass = (r.err == 0) ? 1 : 0;
    r.cyc  = 8 * (settle + 1);
    return r;
  endfunction

  task automatic check_reset_state(input string tag);
    check({tag, "_a"}, obs_ab[1], 0);
    check({tag, "_b"}, obs_ab[0], 0);
    check({tag, "_busy"}, obs_busy, 0);
    check({tag, "_done"}, obs_done, 0);
    check({tag, "_pass"}, obs_pass, 0);
    check({tag, "_err"}, obs_err, 0);
    check({tag, "_fs"}, obs_fs, 0);
    check({tag, "_fv"}, obs_fv, 0);
  endtask

  task automatic run(input int s, input int settle, input int dly, input bit inv,
                     input int errmax, input int repulse_at);
    res_t r;
    int total, c;
    bit seen;
    sel = s;
    r = model(settle, dly, inv, last_ab[s], errmax);
    res_q.push_back(r);
    total = r.cyc;
    for (int i = 0; i < total; i++) ab_q.push_back(tab_ab[i / (settle + 1)]);
    @(negedge clk);
    start[s] = 1'b1;
    @(posedge clk);
    #1 start[s] = 1'b0;
    seen = 1'b0;
    c = 0;
    while (!seen && c <= total + 8) begin
      @(negedge clk);
      if (c == 0) begin
        check("busy_after_start", obs_busy, 1);
        check("done_cleared", obs_done, 0);
      end
      if (obs_done) begin
        seen = 1'b1;
        check("run_cycles", c, total);
      end else if (c < total && ab_q.size() > 0) begin
        check("ab_trace", obs_ab, ab_q.pop_front());
      end
      start[s] = (c == repulse_at);
      c++;
    end
    start[s] = 1'b0;
    if (!seen) check("done_timeout", 0, 1);
    ab_q.delete();
    r = res_q.pop_front();
    check("err_cnt", obs_err, r.err);
    check("fail_valid", obs_fv, r.fv);
    check("fail_step", obs_fs, r.fs);
    check("pass", obs_pass, r.pass);
    check("busy_at_done", obs_busy, 0);
    last_ab[s] = tab_ab[7];
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    sel = 0;
    repeat (3) @(negedge clk);
    check_reset_state("por");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    dly0 = 0; inv0 = 1'b0;
    run(0, 1, 0, 1'b0, 15, -1);      // loopback, clean pass
    inv0 = 1'b1;
    run(0, 1, 0, 1'b1, 15, -1);      // inverted y0: steps 0..6 fail
    inv0 = 1'b0;
    run(0, 1, 0, 1'b0, 15, 4);       // restart from DONE, start re-pulsed at step 2
    dly0 = 2;
    run(0, 1, 2, 1'b0, 15, -1);      // two-cycle delayed DUT, too slow for SETTLE=1
    check("delayed_err_nonzero", (obs_err != 0) ? 1 : 0, 1);

    // Reset during step 3 of an inverted run.
    dly0 = 0; inv0 = 1'b1; sel = 0;
    @(negedge clk);
    start[0] = 1'b1;
    @(posedge clk);
    #1 start[0] = 1'b0;
    repeat (7) @(negedge clk);
    check("err_before_abort", obs_err, 3);
    check("busy_before_abort", obs_busy, 1);
    reset = 1'b1;
    #1;
    check_reset_state("abort");
    @(negedge clk);
    reset = 1'b0;
    last_ab = '{2'b00, 2'b00, 2'b00};
    inv0 = 1'b0;
    run(0, 1, 0, 1'b0, 15, -1);      // clean run after abort

    run(1, 3, 1, 1'b0, 15, -1);      // SETTLE=3, one-cycle delay: pass in 32 cycles
    run(2, 1, 0, 1'b1, 3, -1);       // ERR_W=2: saturates at 3

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
